// File: rtl/vs_codec_pkg.sv
// Shared constants and state encoding for the decoder-side responder of the
// serial control/data link.
package vs_codec_pkg;

  localparam logic [7:0]  OP_WRITE   = 8'h02;
  localparam logic [7:0]  OP_READ    = 8'h03;
  localparam logic [3:0]  ADDR_MODE  = 4'h0;
  localparam logic [3:0]  ADDR_VOL   = 4'hB;
  localparam logic [15:0] MODE_RESET = 16'h0800;
  localparam int          NUM_REGS   = 16;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SCI,
    ST_SDI
  } state_t;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/vs_byte_fifo.sv
// Show-ahead byte FIFO: array storage with a registered head read, plus a
// bypass so a byte written into an empty FIFO is visible on the next cycle.
module vs_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   level_reg;
  logic [7:0]    head_reg;
  logic          do_push;
  logic          do_pop;

  assign full        = (level_reg == FULL_LEVEL);
  assign valid       = (level_reg != '0);
  assign do_pop      = pop && valid;
  assign do_push     = push && !full;
  assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign head        = head_reg;
  assign level       = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!init || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW + 1)'(1);
        2'b01:   level_reg <= level_reg - (AW + 1)'(1);
        default: level_reg <= level_reg;
      endcase
      // The slot being written is the next head only when the FIFO drains to empty.
      head_reg <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/vs_codec_responder.sv
// Decoder-side responder: SCI register access and SDI byte streaming over a
// synchronized SCLK/SI link, with DREQ flow control from the byte FIFO level.
module vs_codec_responder
  import vs_codec_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int DREQ_MARGIN = 32,
  parameter int BOOT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        init,
  input  logic        XRSET,
  input  logic        XCS,
  input  logic        XDCS,
  input  logic        SCLK,
  input  logic        SI,
  output logic        SO,
  output logic        DREQ,
  output logic [15:0] vol,
  output logic [15:0] mode,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow,
  output logic        bad_cmd
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = $clog2(BOOT_CYCLES + 1);
  localparam int NSYNC = 5;
  // Idle levels held by the synchronizers during init: {XRSET, XCS, XDCS, SCLK, SI}
  localparam logic [NSYNC-1:0] SYNC_INIT = 5'b01100;

  logic [NSYNC-1:0] raw_in;
  logic [NSYNC-1:0] sync_in;
  logic xrset_s, xcs_s, xdcs_s, sclk_s, si_s;
  logic sclk_prev_reg, sclk_rise, sclk_fall;

  assign raw_in = {XRSET, XCS, XDCS, SCLK, SI};

  for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk) begin
      if (!init) begin
        meta_reg <= SYNC_INIT[gi];
        sync_reg <= SYNC_INIT[gi];
      end else begin
        meta_reg <= raw_in[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_in[gi] = sync_reg;
  end

  assign {xrset_s, xcs_s, xdcs_s, sclk_s, si_s} = sync_in;

  always_ff @(posedge clk) begin
    if (!init) sclk_prev_reg <= 1'b0;
    else       sclk_prev_reg <= sclk_s;
  end

  assign sclk_rise = sclk_s && !sclk_prev_reg;
  assign sclk_fall = !sclk_s && sclk_prev_reg;

  state_t          state_reg;
  logic [BW-1:0]   boot_cnt_reg;
  logic [4:0]      bit_cnt_reg;
  logic [30:0]     frame_reg;
  logic [6:0]      byte_reg;
  logic [14:0]     shift_reg;
  logic            rd_active_reg;
  logic            so_reg;
  logic            dreq_reg;
  logic            overflow_reg;
  logic            bad_cmd_reg;
  logic [15:0]     regs [NUM_REGS];

  // Frame fields as seen on the rise that captures bit 8, 16 or 32.
  logic [7:0]  op_at_8, op_at_16, op_at_32;
  logic [3:0]  rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  push_byte;
  logic        byte_done;
  logic        fifo_push, fifo_full, free_ok;
  logic [LW-1:0] fifo_level;

  assign op_at_8   = {frame_reg[6:0], si_s};
  assign op_at_16  = frame_reg[14:7];
  assign rd_addr   = {frame_reg[2:0], si_s};
  assign op_at_32  = frame_reg[30:23];
  assign wr_addr   = frame_reg[18:15];
  assign wr_data   = {frame_reg[14:0], si_s};
  assign push_byte = {byte_reg, si_s};

  assign byte_done = (state_reg == ST_SDI) && xrset_s && !xdcs_s && sclk_rise
                     && (bit_cnt_reg == 5'd7);
  assign fifo_push = byte_done && !fifo_full;
  assign free_ok   = (FIFO_DEPTH - int'(fifo_level)) >= DREQ_MARGIN;

  vs_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .init      (init),
    .flush     (!xrset_s),
    .push      (fifo_push),
    .push_data (push_byte),
    .pop       (byte_ready),
    .head      (byte_data),
    .valid     (byte_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!init || !xrset_s) begin
      state_reg     <= ST_BOOT;
      boot_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      frame_reg     <= '0;
      byte_reg      <= '0;
      shift_reg     <= '0;
      rd_active_reg <= 1'b0;
      so_reg        <= 1'b0;
      dreq_reg      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[ADDR_MODE] <= MODE_RESET;
      // A decoder-only reset keeps the sticky error flags for the host to inspect.
      if (!init) begin
        overflow_reg <= 1'b0;
        bad_cmd_reg  <= 1'b0;
      end
    end else begin
      dreq_reg <= (state_reg != ST_BOOT) && free_ok;
      case (state_reg)
        ST_BOOT: begin
          if (boot_cnt_reg == BW'(BOOT_CYCLES - 1)) state_reg <= ST_IDLE;
          else boot_cnt_reg <= boot_cnt_reg + BW'(1);
        end
        ST_IDLE: begin
          if (!xdcs_s) begin
            state_reg   <= ST_SDI;
            bit_cnt_reg <= '0;
          end else if (!xcs_s) begin
            state_reg   <= ST_SCI;
            bit_cnt_reg <= '0;
          end
        end
        ST_SCI: begin
          if (!xdcs_s || xcs_s) begin
            state_reg     <= !xdcs_s ? ST_SDI : ST_IDLE;
            bit_cnt_reg   <= '0;
            rd_active_reg <= 1'b0;
            so_reg        <= 1'b0;
          end else if (sclk_rise) begin
            frame_reg   <= {frame_reg[29:0], si_s};
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7 && !is_known_op(op_at_8)) bad_cmd_reg <= 1'b1;
            if (bit_cnt_reg == 5'd15 && op_at_16 == OP_READ) begin
              shift_reg     <= regs[rd_addr][14:0];
              so_reg        <= regs[rd_addr][15];
              rd_active_reg <= 1'b1;
            end
            if (bit_cnt_reg == 5'd31) begin
              rd_active_reg <= 1'b0;
              so_reg        <= 1'b0;
              if (op_at_32 == OP_WRITE) regs[wr_addr] <= wr_data;
            end
          end else if (sclk_fall && rd_active_reg) begin
            so_reg    <= shift_reg[14];
            shift_reg <= {shift_reg[13:0], 1'b0};
          end
        end
        ST_SDI: begin
          if (xdcs_s) begin
            state_reg   <= xcs_s ? ST_IDLE : ST_SCI;
            bit_cnt_reg <= '0;
          end else if (sclk_rise) begin
            byte_reg    <= push_byte[6:0];
            bit_cnt_reg <= (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
            if (byte_done && fifo_full) overflow_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_BOOT;
      endcase
    end
  end

  assign SO       = so_reg;
  assign DREQ     = dreq_reg;
  assign overflow = overflow_reg;
  assign bad_cmd  = bad_cmd_reg;
  assign vol      = regs[ADDR_VOL];
  assign mode     = regs[ADDR_MODE];

endmodule

// File: tb/tb_vs_codec_responder.sv
// Scoreboard bench for vs_codec_responder: drives SCI/SDI traffic as a master
// would and compares register, SO, FIFO and DREQ behaviour.
module tb_vs_codec_responder;

  localparam int FIFO_DEPTH   = 64;
  localparam int DREQ_MARGIN  = 32;
  localparam int BOOT_CYCLES  = 16;
  // Two synchronizer stages, the boot count, then the registered DREQ.
  localparam int BOOT_LATENCY = 2 + BOOT_CYCLES + 1;

  logic clk = 1'b0;
  logic init, XRSET, XCS, XDCS, SCLK, SI, byte_ready;
  logic SO, DREQ, byte_valid, overflow, bad_cmd;
  logic [15:0] vol, mode;
  logic [7:0]  byte_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] byte_q[$];
  logic       so_q[$];

  always #5 clk = ~clk;

  vs_codec_responder #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DREQ_MARGIN (DREQ_MARGIN),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk        (clk),
    .init       (init),
    .XRSET      (XRSET),
    .XCS        (XCS),
    .XDCS       (XDCS),
    .SCLK       (SCLK),
    .SI         (SI),
    .SO         (SO),
    .DREQ       (DREQ),
    .vol        (vol),
    .mode       (mode),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .overflow   (overflow),
    .bad_cmd    (bad_cmd)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits MSB first from word[31]; SO is sampled late in each high phase.
  task automatic send_bits(input logic [31:0] word, input int n, output logic [31:0] so_seen);
    so_seen = '0;
    for (int i = 0; i < n; i++) begin
      SI = word[31-i];
      tick(4);
      SCLK = 1'b1;
      tick(4);
      so_seen[31-i] = SO;
      SCLK = 1'b0;
    end
    tick(4);
    $display("[tb] shifted %0d bits of %08h", n, word);
  endtask

  task automatic sci_frame(input logic [31:0] word, output logic [31:0] so_seen);
    XCS = 1'b0;
    tick(4);
    send_bits(word, 32, so_seen);
    XCS = 1'b1;
    tick(6);
  endtask

  task automatic sdi_byte(input logic [7:0] b, input bit expect_stored);
    logic [31:0] dummy;
    if (expect_stored) byte_q.push_back(b);
    send_bits({b, 24'h0}, 8, dummy);
  endtask

  task automatic drain(input string name, output int popped);
    logic [7:0] exp;
    popped = 0;
    for (int guard = 0; guard < 2 * FIFO_DEPTH && byte_valid; guard++) begin
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL %s extra_byte: got %02h, required no byte", name, byte_data);
      end else begin
        exp = byte_q.pop_front();
        if (byte_data !== exp) begin
          errors++;
          $display("FAIL %s byte %0d: got %02h, required %02h", name, popped, byte_data, exp);
        end
      end
      $display("[tb] %s popped byte %02h", name, byte_data);
      popped++;
      byte_ready = 1'b1;
      tick(1);
      byte_ready = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_reset;
    init = 1'b0; XRSET = 1'b1; XCS = 1'b1; XDCS = 1'b1;
    SCLK = 1'b0; SI = 1'b0; byte_ready = 1'b0;
    tick(5);
    checks++;
    if ({SO, DREQ, overflow, bad_cmd, byte_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset outputs: got SO/DREQ/ovf/bad/valid=%b, required 00000",
               {SO, DREQ, overflow, bad_cmd, byte_valid});
    end
    checks++;
    if (mode !== 16'h0800 || vol !== 16'h0000) begin
      errors++;
      $display("FAIL reset regs: got mode=%h vol=%h, required 0800/0000", mode, vol);
    end
    init = 1'b1;
    tick(BOOT_LATENCY - 1);
    checks++;
    if (DREQ !== 1'b0) begin
      errors++;
      $display("FAIL boot dreq_early: got %b, required 0", DREQ);
    end
    tick(1);
    checks++;
    if (DREQ !== 1'b1) begin
      errors++;
      $display("FAIL boot dreq_ready: got %b, required 1", DREQ);
    end
    $display("[tb] boot complete");
  endtask

  task automatic test_sci_write_read;
    logic [31:0] seen;
    logic [15:0] exp_word;
    logic        exp_bit;
    sci_frame(32'h020B6666, seen);
    checks++;
    if (vol !== 16'h6666 || mode !== 16'h0800) begin
      errors++;
      $display("FAIL sci_write: got vol=%h mode=%h, required 6666/0800", vol, mode);
    end
    for (int r = 0; r < 2; r++) begin
      exp_word = (r == 0) ? 16'h6666 : 16'h0800;
      for (int k = 15; k >= 0; k--) so_q.push_back(exp_word[k]);
      sci_frame((r == 0) ? 32'h030B0000 : 32'h03000000, seen);
      for (int i = 15; i <= 30; i++) begin
        exp_bit = so_q.pop_front();
        checks++;
        if (seen[31-i] !== exp_bit) begin
          errors++;
          $display("FAIL sci_read%0d so_bit %0d: got %b, required %b", r, i + 1, seen[31-i], exp_bit);
        end
      end
      checks++;
      if (seen[31:17] !== 15'h0 || seen[0] !== 1'b0 || SO !== 1'b0) begin
        errors++;
        $display("FAIL sci_read%0d so_idle: got samples=%08h SO=%b, required zeros outside data",
                 r, seen, SO);
      end
    end
  endtask

  task automatic test_sdi_stream;
    logic [31:0] dummy;
    int popped;
    XCS = 1'b0;
    XDCS = 1'b0;
    tick(4);
    byte_q.push_back(8'h49); byte_q.push_back(8'h44);
    byte_q.push_back(8'h33); byte_q.push_back(8'h03);
    send_bits(32'h49443303, 32, dummy);
    XCS = 1'b1;
    XDCS = 1'b1;
    tick(6);
    checks++;
    if (vol !== 16'h6666 || mode !== 16'h0800) begin
      errors++;
      $display("FAIL sdi_no_write: got vol=%h mode=%h, required 6666/0800", vol, mode);
    end
    drain("sdi_stream", popped);
    checks++;
    if (popped !== 4) begin
      errors++;
      $display("FAIL sdi_count: got %0d bytes, required 4", popped);
    end
  endtask

  task automatic test_backpressure;
    int popped;
    byte_ready = 1'b0;
    XDCS = 1'b0;
    tick(4);
    for (int i = 0; i < 32; i++) sdi_byte(8'($urandom_range(0, 255)), 1'b1);
    tick(2);
    checks++;
    if (DREQ !== 1'b1) begin
      errors++;
      $display("FAIL bp_dreq_at_32: got %b, required 1", DREQ);
    end
    sdi_byte(8'($urandom_range(0, 255)), 1'b1);
    tick(2);
    checks++;
    if (DREQ !== 1'b0) begin
      errors++;
      $display("FAIL bp_dreq_at_33: got %b, required 0", DREQ);
    end
    for (int i = 0; i < 31; i++) sdi_byte(8'($urandom_range(0, 255)), 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_overflow_at_full: got %b, required 0", overflow);
    end
    sdi_byte(8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b, required 1", overflow);
    end
    XDCS = 1'b1;
    tick(6);
    drain("backpressure", popped);
    checks++;
    if (popped !== FIFO_DEPTH) begin
      errors++;
      $display("FAIL bp_level: got %0d bytes, required %0d", popped, FIFO_DEPTH);
    end
    tick(3);
    checks++;
    if (DREQ !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_drain: got DREQ=%b overflow=%b, required 1/1", DREQ, overflow);
    end
  endtask

  task automatic test_abort;
    logic [31:0] dummy;
    int popped;
    XCS = 1'b0;
    tick(4);
    send_bits(32'h020B1234, 20, dummy);
    XCS = 1'b1;
    tick(6);
    checks++;
    if (vol !== 16'h6666) begin
      errors++;
      $display("FAIL abort_sci: got vol=%h, required 6666", vol);
    end
    XDCS = 1'b0;
    tick(4);
    send_bits(32'hA8000000, 5, dummy);
    XDCS = 1'b1;
    tick(6);
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_sdi: got byte_valid=%b, required 0", byte_valid);
    end
    sci_frame(32'h020B00AA, dummy);
    checks++;
    if (vol !== 16'h00AA) begin
      errors++;
      $display("FAIL abort_then_write: got vol=%h, required 00aa", vol);
    end
    XDCS = 1'b0;
    tick(4);
    sdi_byte(8'h5A, 1'b1);
    XDCS = 1'b1;
    tick(6);
    drain("abort_then_byte", popped);
    checks++;
    if (popped !== 1) begin
      errors++;
      $display("FAIL abort_then_byte count: got %0d, required 1", popped);
    end
  endtask

  task automatic test_bad_cmd;
    logic [31:0] dummy;
    checks++;
    if (bad_cmd !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_before: got %b, required 0", bad_cmd);
    end
    sci_frame(32'h050B4321, dummy);
    checks++;
    if (bad_cmd !== 1'b1 || vol !== 16'h00AA) begin
      errors++;
      $display("FAIL bad_cmd: got bad_cmd=%b vol=%h, required 1/00aa", bad_cmd, vol);
    end
  endtask

  task automatic test_xrset_mid_sdi;
    logic [31:0] dummy;
    XDCS = 1'b0;
    tick(4);
    sdi_byte(8'h11, 1'b0);
    sdi_byte(8'h22, 1'b0);
    send_bits(32'hE0000000, 3, dummy);
    checks++;
    if (byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL xrset_pre: got byte_valid=%b, required 1", byte_valid);
    end
    XRSET = 1'b0;
    tick(4);
    checks++;
    if ({byte_valid, DREQ, SO} !== 3'b000 || vol !== 16'h0000 || mode !== 16'h0800) begin
      errors++;
      $display("FAIL xrset_clear: got valid/DREQ/SO=%b vol=%h mode=%h, required 000/0000/0800",
               {byte_valid, DREQ, SO}, vol, mode);
    end
    checks++;
    if (overflow !== 1'b1 || bad_cmd !== 1'b1) begin
      errors++;
      $display("FAIL xrset_sticky: got overflow=%b bad_cmd=%b, required 1/1", overflow, bad_cmd);
    end
    XDCS = 1'b1;
    tick(2);
    XRSET = 1'b1;
    tick(BOOT_LATENCY - 1);
    checks++;
    if (DREQ !== 1'b0) begin
      errors++;
      $display("FAIL xrset_reboot_early: got DREQ=%b, required 0", DREQ);
    end
    tick(1);
    checks++;
    if (DREQ !== 1'b1) begin
      errors++;
      $display("FAIL xrset_reboot_ready: got DREQ=%b, required 1", DREQ);
    end
  endtask

  task automatic test_init_mid;
    logic [31:0] dummy;
    sci_frame(32'h020B1111, dummy);
    checks++;
    if (vol !== 16'h1111) begin
      errors++;
      $display("FAIL init_pre_write: got vol=%h, required 1111", vol);
    end
    XDCS = 1'b0;
    tick(4);
    sdi_byte(8'h77, 1'b0);
    XDCS = 1'b1;
    tick(4);
    checks++;
    if (byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL init_pre_byte: got byte_valid=%b, required 1", byte_valid);
    end
    init = 1'b0;
    tick(1);
    checks++;
    if ({SO, DREQ, overflow, bad_cmd, byte_valid} !== 5'b0 || mode !== 16'h0800 || vol !== 16'h0000) begin
      errors++;
      $display("FAIL init_mid: got SO/DREQ/ovf/bad/valid=%b mode=%h vol=%h, required 00000/0800/0000",
               {SO, DREQ, overflow, bad_cmd, byte_valid}, mode, vol);
    end
    init = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_sci_write_read();
    test_sdi_stream();
    test_backpressure();
    test_abort();
    test_bad_cmd();
    test_xrset_mid_sdi();
    test_init_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vs_codec_responder.md
Name: vs_codec_responder

Overview:
- Synthesizable model of the audio-decoder side of the serial control/data link driven by the MP3 player master.
- Receives SCI register commands on XCS and SDI stream data on XDCS, both over SCLK/SI.
- Drives DREQ from its internal byte-FIFO level and returns SCI read data on SO.
- Used in simulation and on-board loopback in place of the external decoder chip. The byte stream goes to a downstream consumer through a valid/ready port.

Parameters:
- FIFO_DEPTH, 64, SDI byte FIFO depth (power of 2).
- DREQ_MARGIN, 32, DREQ is high only while free FIFO slots are at least this value.
- BOOT_CYCLES, 16, clk cycles DREQ stays low after XRSET rises.

Ports:
- clk  input  1  system clock; all logic on posedge.
- init  input  1  synchronous active-low reset.
- XRSET  input  1  decoder hardware reset, active low.
- XCS  input  1  SCI chip select, active low.
- XDCS  input  1  SDI chip select, active low.
- SCLK  input  1  serial clock from master.
- SI  input  1  serial data in, MSB first.
- SO  output  1  SCI read data out.
- DREQ  output  1  data request / ready to master.
- vol  output  16  current SCI_VOL register (0x0B).
- mode  output  16  current SCI_MODE register (0x00).
- byte_data  output  8  head-of-FIFO byte.
- byte_valid  output  1  FIFO not empty.
- byte_ready  input  1  consumer pops the head when byte_valid and byte_ready are both high.
- overflow  output  1  sticky flag: an SDI byte arrived while the FIFO was full.
- bad_cmd  output  1  sticky flag: an SCI opcode other than 0x02 or 0x03 was received.

Behaviour:
- **Input sampling:** XRSET, XCS, XDCS, SCLK and SI each pass through a 2-flop synchronizer.
  - SCLK rise and fall are detected from the synchronized SCLK and its previous value.
  - Total input-to-action latency: 3 clk.
- **Reset (init low):**
  - Outputs: SO=0, DREQ=0, overflow=0, bad_cmd=0, byte_valid=0.
  - Registers: all 16 regs cleared, then mode=0x0800, vol=0x0000.
  - FIFO emptied; state=BOOT, boot counter=0.
  - init has priority over every other event.
- **XRSET low (synchronized):** same effect as init, except the sticky flags hold their values. State stays BOOT while XRSET is low.
- **States:** BOOT, IDLE, SCI, SDI.
  - **BOOT:** counts clk cycles while XRSET is high. At BOOT_CYCLES → IDLE. DREQ=0 throughout.
  - **IDLE:**
    - XDCS low → SDI.
    - Else XCS low → SCI.
    - Bit counter cleared on entry to SCI or SDI.
  - **SCI:**
    - Shift SI on each SCLK rise into a 32-bit frame: opcode[31:24], addr[23:16], data[15:0].
    - After bit 16 is captured with opcode 0x03: load reg[addr[3:0]] into the output shifter. SO presents bit 15 immediately, then shifts on each SCLK fall. SO=0 otherwise.
    - After bit 32 with opcode 0x02: write reg[addr[3:0]] := data.
    - Any other opcode sets bad_cmd; no write.
    - XCS high → IDLE. A partial frame is discarded with no write.
    - XDCS low → SDI. The partial SCI frame is aborted.
  - **SDI:**
    - Shift SI on each SCLK rise.
    - Every 8th bit pushes the byte into the FIFO. If the FIFO is full, the byte is dropped and overflow is set.
    - XDCS high → IDLE, or → SCI if XCS is low. A partial byte is discarded.
    - XDCS has priority over XCS whenever both are low.
- **FIFO and DREQ:**
  - Simultaneous push and pop is allowed; the level stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Outside BOOT: DREQ = (FIFO_DEPTH − level ≥ DREQ_MARGIN). DREQ is registered, so it updates 1 clk after a level change.
- **Register outputs:** vol and mode are direct register outputs. They update the cycle after the write completes.

Decomposition:
- Shared package vs_codec_pkg holds:
  - opcode constants OP_WRITE=0x02, OP_READ=0x03;
  - register addresses ADDR_MODE=0x0, ADDR_VOL=0xB;
  - MODE_RESET=0x0800;
  - state enum.
- One sub-module: vs_byte_fifo (FIFO_DEPTH×8, synchronous, level output).

Test Plan:
- **Boot:** init low 5 clk, XRSET high → DREQ=0 for BOOT_CYCLES=16 clk after the synchronizer, then 1; mode=0x0800, vol=0x0000.
- **SCI write then read:**
  - Write frame 0x020B6666 → vol=0x6666 one clk after the 32nd SCLK rise.
  - Read frame 0x030B0000 → SO bits 16–31 equal 0x6666, MSB first.
- **SDI stream:** word 0x49443303 with XCS and XDCS both low → FIFO bytes 0x49, 0x44, 0x33, 0x03 popped in order with byte_ready=1. No SCI write occurs.
- **Backpressure:** byte_ready=0, push 33 bytes → DREQ falls when level reaches 33 (free 31). Push 31 more → full. A 65th byte sets overflow; the level stays 64.
- **Abort:** XCS rises after 20 bits of 0x020B1234 → vol unchanged. XDCS rises after 5 bits → no FIFO push.
- **Mid-operation resets:**
  - XRSET low mid-SDI → FIFO empty, registers at reset values, overflow held.
  - init low → all outputs at reset values on the next clk.
